cache_tag_ctrl: RTL
===================

// Module: cache_tag_ctrl
// PURPOSE
//  Tag/state controller for the 2-way set-associative cache. Sits directly downstream of the
//  address splitter and consumes its tag/index fields. Holds the tag, valid, dirty and LRU
//  state per set, and reports hit/miss and the selected way. On a miss it runs the refill
//  handshake to memory, including a dirty-victim writeback flag.
// PARAMETERS
//  ADDR_WIDTH   32  width of refill/writeback line addresses
//  TAG_BITS     22  tag field width
//  INDEX_BITS   4   set index width; NUM_SETS = 2**INDEX_BITS (16)
//  OFFSET_BITS  6   line offset width; zeroed in emitted line addresses
//  N_WAYS       2   associativity; only 2 is supported (elaboration error otherwise)
// PORTS
//  clk              in   1           clock, all state on rising edge
//  rst_n            in   1           asynchronous active-low reset
//  req_valid        in   1           lookup request valid
//  req_ready        out  1           controller can accept a request
//  req_tag          in   TAG_BITS    tag of request
//  req_index        in   INDEX_BITS  set index of request
//  req_write        in   1           request is a store (marks line dirty)
//  invalidate_all   in   1           level; clears all valid/dirty/LRU when sampled in IDLE
//  resp_valid       out  1           one-cycle response pulse
//  resp_hit         out  1           1=hit, 0=miss (line now refilled)
//  resp_way         out  1           way holding the line
//  refill_req_valid out  1           refill request to memory
//  refill_req_ready in   1           memory accepts refill request
//  refill_addr      out  ADDR_WIDTH  {tag,index,OFFSET zeros} of missing line
//  refill_wb        out  1           victim is valid&dirty; memory must write it back first
//  refill_wb_addr   out  ADDR_WIDTH  {victim tag,index,OFFSET zeros}
//  refill_done      in   1           one-cycle pulse: refill (and writeback) complete
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, all valid/dirty/lru=0, captured request regs=0.
//    resp_valid=0, resp_hit=0, resp_way=0, refill_req_valid=0, refill_wb=0, addrs=0.
//    Reset mid-refill abandons the transaction; refill_req_valid drops immediately.
//  - req_ready = (state==IDLE) && !invalidate_all (combinational).
//  - FSM: IDLE -> LOOKUP -> (hit) RESP | (miss) MISS_REQ -> MISS_WAIT -> RESP -> IDLE.
//    IDLE:      invalidate_all=1 clears all set state (priority over req). Else on
//               req_valid&&req_ready, capture tag/index/write and go to LOOKUP.
//    LOOKUP:    hit_w = valid[idx][w] && tag[idx][w]==tag. On hit: dirty|=write,
//               lru[idx]=~w, and go to RESP with hit=1. On miss, choose the victim:
//               way0 if invalid, else way1 if invalid, else lru[idx]. Go to MISS_REQ.
//    MISS_REQ:  refill_req_valid=1. refill_addr, refill_wb and refill_wb_addr are
//               registered and stable until the handshake. Go to MISS_WAIT on
//               valid&&ready (same edge).
//    MISS_WAIT: wait for refill_done. Then install tag in the victim, valid=1,
//               dirty=write, lru[idx]=~victim, and go to RESP with hit=0.
//    RESP:      resp_valid=1 for exactly one cycle; resp_hit/resp_way are registered
//               and valid that cycle. Return to IDLE.
//  - Latency: hit response 2 cycles after the accept edge; miss response 1 cycle after
//    the refill_done edge.
//  - refill_done outside MISS_WAIT and invalidate_all outside IDLE are ignored.
//  - Both ways hit (corrupt state): way0 wins.
//  - LRU semantics: lru[s] = way to evict next. Reset/invalidate sets it to 0.
// TESTING
//  1 Reset, then req tag=0x4 idx=1 rd: miss, refill_addr=0x00001040, refill_wb=0;
//    refill_done -> resp_hit=0 way=0 (response 1 cycle after done).
//  2 Repeat tag=0x4 idx=1: resp_valid 2 cycles after accept, hit=1, way=0, no refill_req.
//  3 Write tag=0x5 idx=1 (fills way1 dirty), read tag=0x4, then read tag=0x6 idx=1:
//    victim way1, refill_wb=1, refill_wb_addr=0x00001440.
//  4 Hold refill_req_ready=0 for 5 cycles: refill_req_valid and addrs stable, then accept.
//  5 invalidate_all in IDLE, re-request tag=0x4 idx=1 -> miss.
//  6 Assert rst_n=0 in MISS_WAIT: refill_req_valid=0 and resp_valid=0 immediately;
//    after release, req_ready=1 and every lookup misses.

Source files
------------

// File: rtl/cache_tag_ctrl.sv
// Tag/state controller for a 2-way set-associative cache: hit/miss lookup, LRU tracking,
// and the refill handshake to memory with a dirty-victim writeback flag.
module cache_tag_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned TAG_BITS    = 22,
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned OFFSET_BITS = 6,
  parameter int unsigned N_WAYS      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic                  req_write,
  input  logic                  invalidate_all,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  resp_way,
  output logic                  refill_req_valid,
  input  logic                  refill_req_ready,
  output logic [ADDR_WIDTH-1:0] refill_addr,
  output logic                  refill_wb,
  output logic [ADDR_WIDTH-1:0] refill_wb_addr,
  input  logic                  refill_done
);

  localparam int unsigned NumSets = 2 ** INDEX_BITS;

  if (N_WAYS != 2) begin : gen_ways_check
    $error("cache_tag_ctrl: only N_WAYS == 2 is supported");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissWait,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Per-set line state
  logic [TAG_BITS-1:0]           tag_q [NumSets];
  logic [TAG_BITS-1:0]           tag_d [NumSets];
  logic [TAG_BITS-1:0]           tag_w1_q [NumSets];
  logic [TAG_BITS-1:0]           tag_w1_d [NumSets];
  logic [NumSets-1:0][1:0]       valid_q, valid_d;
  logic [NumSets-1:0][1:0]       dirty_q, dirty_d;
  logic [NumSets-1:0]            lru_q, lru_d;

  // Captured request and registered outputs
  logic [TAG_BITS-1:0]           req_tag_q, req_tag_d;
  logic [INDEX_BITS-1:0]         req_index_q, req_index_d;
  logic                          req_write_q, req_write_d;
  logic                          victim_q, victim_d;
  logic                          resp_hit_q, resp_hit_d;
  logic                          resp_way_q, resp_way_d;
  logic [ADDR_WIDTH-1:0]         refill_addr_q, refill_addr_d;
  logic                          refill_wb_q, refill_wb_d;
  logic [ADDR_WIDTH-1:0]         refill_wb_addr_q, refill_wb_addr_d;

  logic [TAG_BITS-1:0]           set_tag0, set_tag1, victim_tag;
  logic                          hit0, hit1, hit, hit_way, victim;

  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_BITS-1:0]   t,
                                                      input logic [INDEX_BITS-1:0] i);
    line_addr = ADDR_WIDTH'({t, i, {OFFSET_BITS{1'b0}}});
  endfunction

  // Lookup of the captured request against its set
  always_comb begin
    set_tag0   = tag_q[req_index_q];
    set_tag1   = tag_w1_q[req_index_q];
    hit0       = valid_q[req_index_q][0] && (set_tag0 == req_tag_q);
    hit1       = valid_q[req_index_q][1] && (set_tag1 == req_tag_q);
    hit        = hit0 || hit1;
    hit_way    = hit0 ? 1'b0 : 1'b1;
    if (!valid_q[req_index_q][0]) begin
      victim = 1'b0;
    end else if (!valid_q[req_index_q][1]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[req_index_q];
    end
    victim_tag = victim ? set_tag1 : set_tag0;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!invalidate_all && req_valid) state_d = StLookup;
      end
      StLookup:   state_d = hit ? StResp : StMissReq;
      StMissReq: begin
        if (refill_req_ready) state_d = StMissWait;
      end
      StMissWait: begin
        if (refill_done) state_d = StResp;
      end
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready        = (state_q == StIdle) && !invalidate_all;
    resp_valid       = (state_q == StResp);
    refill_req_valid = (state_q == StMissReq);
    resp_hit         = resp_hit_q;
    resp_way         = resp_way_q;
    refill_addr      = refill_addr_q;
    refill_wb        = refill_wb_q;
    refill_wb_addr   = refill_wb_addr_q;
  end

  // Datapath next state
  always_comb begin
    tag_d            = tag_q;
    tag_w1_d         = tag_w1_q;
    valid_d          = valid_q;
    dirty_d          = dirty_q;
    lru_d            = lru_q;
    req_tag_d        = req_tag_q;
    req_index_d      = req_index_q;
    req_write_d      = req_write_q;
    victim_d         = victim_q;
    resp_hit_d       = resp_hit_q;
    resp_way_d       = resp_way_q;
    refill_addr_d    = refill_addr_q;
    refill_wb_d      = refill_wb_q;
    refill_wb_addr_d = refill_wb_addr_q;
    unique case (state_q)
      StIdle: begin
        if (invalidate_all) begin
          valid_d = '0;
          dirty_d = '0;
          lru_d   = '0;
        end else if (req_valid) begin
          req_tag_d   = req_tag;
          req_index_d = req_index;
          req_write_d = req_write;
        end
      end
      StLookup: begin
        if (hit) begin
          dirty_d[req_index_q][hit_way] = dirty_q[req_index_q][hit_way] | req_write_q;
          lru_d[req_index_q]            = ~hit_way;
          resp_hit_d                    = 1'b1;
          resp_way_d                    = hit_way;
        end else begin
          victim_d         = victim;
          refill_addr_d    = line_addr(req_tag_q, req_index_q);
          refill_wb_d      = valid_q[req_index_q][victim] && dirty_q[req_index_q][victim];
          refill_wb_addr_d = line_addr(victim_tag, req_index_q);
        end
      end
      StMissWait: begin
        if (refill_done) begin
          if (victim_q) begin
            tag_w1_d[req_index_q] = req_tag_q;
          end else begin
            tag_d[req_index_q] = req_tag_q;
          end
          valid_d[req_index_q][victim_q] = 1'b1;
          dirty_d[req_index_q][victim_q] = req_write_q;
          lru_d[req_index_q]             = ~victim_q;
          resp_hit_d                     = 1'b0;
          resp_way_d                     = victim_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NumSets; s++) begin
        tag_q[s]    <= '0;
        tag_w1_q[s] <= '0;
      end
      valid_q          <= '0;
      dirty_q          <= '0;
      lru_q            <= '0;
      req_tag_q        <= '0;
      req_index_q      <= '0;
      req_write_q      <= 1'b0;
      victim_q         <= 1'b0;
      resp_hit_q       <= 1'b0;
      resp_way_q       <= 1'b0;
      refill_addr_q    <= '0;
      refill_wb_q      <= 1'b0;
      refill_wb_addr_q <= '0;
    end else begin
      tag_q            <= tag_d;
      tag_w1_q         <= tag_w1_d;
      valid_q          <= valid_d;
      dirty_q          <= dirty_d;
      lru_q            <= lru_d;
      req_tag_q        <= req_tag_d;
      req_index_q      <= req_index_d;
      req_write_q      <= req_write_d;
      victim_q         <= victim_d;
      resp_hit_q       <= resp_hit_d;
      resp_way_q       <= resp_way_d;
      refill_addr_q    <= refill_addr_d;
      refill_wb_q      <= refill_wb_d;
      refill_wb_addr_q <= refill_wb_addr_d;
    end
  end

endmodule
